mul_accumulator: RTL and testbench

- Downstream stage of the iterative radix-4 Booth multiplier inside a systolic-array PE.
- Consumes one product per multiplier result window and accumulates a programmable-length dot product into a wider register.
- Presents the finished sum with a valid/ready handshake to the array's drain path.

---
 rtl/mac_pkg.sv | 18 +
 rtl/acc_add_sat.sv | 32 +++
 rtl/mul_accumulator.sv | 64 ++++++
 tb/tb_mul_accumulator.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM states, default widths and saturation limits for mul_accumulator.
package mac_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;
  localparam int ACC_W_DEF = 40;
  localparam int LEN_W_DEF = 8;
  localparam int SAT_W = 128;
  // Limits are returned as raw bit patterns; callers truncate to their accumulator width.
  function automatic logic [SAT_W-1:0] sat_max(input int w, input bit s);
    return s ? (SAT_W'(1) << (w - 1)) - SAT_W'(1) : (SAT_W'(1) << w) - SAT_W'(1);
  endfunction
  function automatic logic [SAT_W-1:0] sat_min(input int w, input bit s);
    return s ? SAT_W'(1) << (w - 1) : '0;
  endfunction
endpackage

// File: rtl/acc_add_sat.sv
// acc_add_sat: extends a product, adds it to the accumulator and flags overflow.
// Clamps on overflow when ACC_SAT_EN is defined, otherwise wraps.
module acc_add_sat
  import mac_pkg::*;
#(
  parameter int WIDTH_MUL = 32,
  parameter int WIDTH_ACC = ACC_W_DEF,
  parameter int SIGNED    = 0
) (
  input  logic [WIDTH_ACC-1:0] acc,
  input  logic [WIDTH_MUL-1:0] product,
  output logic [WIDTH_ACC-1:0] sum,
  output logic                 ovf_bit
);
  logic [WIDTH_ACC-1:0] ext, wrap;
  logic [WIDTH_ACC:0]   raw;
  always_comb begin
    ext = SIGNED != 0 ? WIDTH_ACC'($signed(product)) : WIDTH_ACC'(product);
    raw = {1'b0, acc} + {1'b0, ext};
    wrap = raw[WIDTH_ACC-1:0];
    ovf_bit = SIGNED != 0 ? (acc[WIDTH_ACC-1] == ext[WIDTH_ACC-1]) && (wrap[WIDTH_ACC-1] != acc[WIDTH_ACC-1])
                          : raw[WIDTH_ACC];
`ifdef ACC_SAT_EN
    // Signed overflow direction follows the shared operand sign.
    sum = !ovf_bit ? wrap
        : (SIGNED != 0 && acc[WIDTH_ACC-1]) ? WIDTH_ACC'(sat_min(WIDTH_ACC, SIGNED != 0))
        : WIDTH_ACC'(sat_max(WIDTH_ACC, SIGNED != 0));
`else
    sum = wrap;
`endif
  end
endmodule

// File: rtl/mul_accumulator.sv
// mul_accumulator: accumulates a programmable-length dot product and hands it off via valid/ready.
// Optional ACC_SAT_EN selects clamping instead of wrap-around on overflow.
module mul_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH_MUL = 32,
  parameter int WIDTH_ACC = ACC_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 ready_start,
  input  logic [WIDTH_MUL-1:0] product_in,
  input  logic                 product_vld,
  output logic [WIDTH_ACC-1:0] acc_out,
  output logic                 acc_vld,
  input  logic                 acc_rdy,
  output logic                 ovf
);
  state_e               state_q;
  logic [LEN_W-1:0]     len_q, cnt_q, cnt_d;
  logic [WIDTH_ACC-1:0] acc_q, acc_out_q, sum;
  logic                 ovf_q, ovf_bit, accept;
  acc_add_sat #(.WIDTH_MUL(WIDTH_MUL), .WIDTH_ACC(WIDTH_ACC), .SIGNED(SIGNED)) u_add (
    .acc(acc_q), .product(product_in), .sum(sum), .ovf_bit(ovf_bit)
  );
  assign ready_start = state_q == IDLE || (state_q == HOLD && acc_rdy);
  assign accept = start && ready_start;
  assign cnt_d = cnt_q + LEN_W'(1);
  assign acc_out = acc_out_q;
  assign acc_vld = state_q == HOLD;
  assign ovf = ovf_q;
  // Accepting a start wins over draining HOLD, giving back-to-back results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      len_q   <= len;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= len == '0 ? HOLD : ACCUM;
      if (len == '0) acc_out_q <= '0;
    end else if (state_q == ACCUM && product_vld) begin
      acc_q <= sum;
      ovf_q <= ovf_q | ovf_bit;
      cnt_q <= cnt_d;
      if (cnt_d == len_q) begin
        state_q   <= HOLD;
        acc_out_q <= sum;
      end
    end else if (state_q == HOLD && acc_rdy) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb_mul_accumulator: directed vectors against signed-40, unsigned-40 and signed-32 instances.
module tb_mul_accumulator;
  logic        clk = 0, rst_n = 0, start = 0, product_vld = 0, acc_rdy = 0;
  logic [7:0]  len = '0;
  logic [31:0] product_in = '0;
  logic [2:0]  rs, vld, ovf;
  logic [39:0] acc_s, acc_u;
  logic [31:0] acc_n;
  int tests = 0, fails = 0;
  bit sat;
  always #5 clk = ~clk;
  mul_accumulator #(.WIDTH_MUL(32), .WIDTH_ACC(40), .LEN_W(8), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .ready_start(rs[0]), .product_in(product_in),
    .product_vld(product_vld), .acc_out(acc_s), .acc_vld(vld[0]), .acc_rdy(acc_rdy), .ovf(ovf[0]));
  mul_accumulator #(.WIDTH_MUL(32), .WIDTH_ACC(40), .LEN_W(8), .SIGNED(0)) u_u (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .ready_start(rs[1]), .product_in(product_in),
    .product_vld(product_vld), .acc_out(acc_u), .acc_vld(vld[1]), .acc_rdy(acc_rdy), .ovf(ovf[1]));
  mul_accumulator #(.WIDTH_MUL(32), .WIDTH_ACC(32), .LEN_W(8), .SIGNED(1)) u_n (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .ready_start(rs[2]), .product_in(product_in),
    .product_vld(product_vld), .acc_out(acc_n), .acc_vld(vld[2]), .acc_rdy(acc_rdy), .ovf(ovf[2]));
  typedef struct {
    int               sel;
    logic [7:0]       len;
    logic [3:0][31:0] p;
    logic [39:0]      exp_acc;
    logic             exp_ovf;
  } vec_t;
  vec_t vt[7];
  function automatic logic [39:0] acc_of(input int sel);
    return sel == 0 ? acc_s : sel == 1 ? acc_u : {8'h0, acc_n};
  endfunction
  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input int k);
    chk($sformatf("v%0d ready", k), 40'(rs[v.sel]), 40'd1);
    start = 1; len = v.len;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < int'(v.len); i++) begin
      if (i == int'(v.len) - 1) chk($sformatf("v%0d early_vld", k), 40'(vld[v.sel]), 40'd0);
      product_vld = 1; product_in = v.p[i];
      @(negedge clk);
    end
    product_vld = 0;
    chk($sformatf("v%0d vld", k), 40'(vld[v.sel]), 40'd1);
    chk($sformatf("v%0d acc", k), acc_of(v.sel), v.exp_acc);
    chk($sformatf("v%0d ovf", k), 40'(ovf[v.sel]), 40'(v.exp_ovf));
    acc_rdy = 1;
    @(negedge clk);
    acc_rdy = 0;
    chk($sformatf("v%0d drained", k), 40'(vld[v.sel]), 40'd0);
  endtask
  initial begin
`ifdef ACC_SAT_EN
    sat = 1;
`else
    sat = 0;
`endif
    vt[0] = '{0, 8'd3, {32'd0, 32'd7, 32'hFFFFFFFD, 32'd5}, 40'd9, 1'b0};
    vt[1] = '{1, 8'd2, {32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF}, 40'h01FFFFFFFE, 1'b0};
    vt[2] = '{2, 8'd2, {32'd0, 32'd0, 32'd1, 32'h7FFFFFFF}, sat ? 40'h7FFFFFFF : 40'h80000000, 1'b1};
    vt[3] = '{0, 8'd2, {32'd0, 32'd0, 32'hFFFFFFFA, 32'hFFFFFFFB}, 40'hFFFFFFFFF5, 1'b0};
    vt[4] = '{1, 8'd4, {32'd4, 32'd3, 32'd2, 32'd1}, 40'd10, 1'b0};
    vt[5] = '{2, 8'd2, {32'd0, 32'd0, 32'hFFFFFFFF, 32'h80000000}, sat ? 40'h80000000 : 40'h7FFFFFFF, 1'b1};
    vt[6] = '{2, 8'd1, {32'd0, 32'd0, 32'd0, 32'd3}, 40'd3, 1'b0};
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst acc%0d", s), acc_of(s), 40'd0);
      chk($sformatf("rst vld%0d", s), 40'(vld[s]), 40'd0);
      chk($sformatf("rst ovf%0d", s), 40'(ovf[s]), 40'd0);
      chk($sformatf("rst rdy%0d", s), 40'(rs[s]), 40'd1);
    end
    rst_n = 1;
    @(negedge clk);
    for (int k = 0; k < 7; k++) run_vec(vt[k], k);
    // len==0 result held under backpressure while stray products arrive
    start = 1; len = 8'd0;
    @(negedge clk);
    start = 0;
    product_vld = 1; product_in = 32'd123;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("len0 vld%0d", i), 40'(vld[0]), 40'd1);
      chk($sformatf("len0 acc%0d", i), acc_s, 40'd0);
      @(negedge clk);
    end
    product_vld = 0;
    chk("len0 busy", 40'(rs[0]), 40'd0);
    acc_rdy = 1;
    @(negedge clk);
    acc_rdy = 0;
    // back-to-back: restart in the same cycle the result is taken
    start = 1; len = 8'd1;
    @(negedge clk);
    start = 0; product_vld = 1; product_in = 32'd9;
    @(negedge clk);
    product_vld = 0;
    chk("b2b first", acc_s, 40'd9);
    acc_rdy = 1; start = 1; len = 8'd1;
    #1 chk("b2b ready", 40'(rs[0]), 40'd1);
    @(negedge clk);
    acc_rdy = 0; start = 0;
    chk("b2b no_idle_vld", 40'(vld[0]), 40'd0);
    chk("b2b no_idle_rdy", 40'(rs[0]), 40'd0);
    product_vld = 1; product_in = 32'd4;
    @(negedge clk);
    product_vld = 0;
    chk("b2b second_vld", 40'(vld[0]), 40'd1);
    chk("b2b second", acc_s, 40'd4);
    acc_rdy = 1;
    @(negedge clk);
    acc_rdy = 0;
    // reset mid-accumulation after overflow has latched
    start = 1; len = 8'd3;
    @(negedge clk);
    start = 0; product_vld = 1; product_in = 32'h7FFFFFFF;
    @(negedge clk);
    product_in = 32'd1;
    @(negedge clk);
    product_vld = 0;
    chk("mid ovf", 40'(ovf[2]), 40'd1);
    chk("mid vld", 40'(vld[2]), 40'd0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort ovf", 40'(ovf[2]), 40'd0);
    chk("abort vld", 40'(vld[2]), 40'd0);
    chk("abort rdy", 40'(rs[2]), 40'd1);
    chk("abort acc", acc_of(2), 40'd0);
    start = 1; len = 8'd1;
    @(negedge clk);
    start = 0; product_vld = 1; product_in = 32'd2;
    @(negedge clk);
    product_vld = 0;
    chk("after rst acc_s", acc_s, 40'd2);
    chk("after rst acc_n", acc_of(2), 40'd2);
    chk("after rst vld", 40'(vld[0]), 40'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
